functional_unit: RTL

Single-issue execution slot on the receive side of the reservation-station issue interface. It accepts one issued micro-op (ALU op or load/store address generation), runs it for a fixed latency, then holds the result until the common-data-bus arbiter grants writeback. Three instances (FU1..FU3) sit between the reservation station and the CDB arbiter. Each instance drives its own `fu_ready` back to the reservation station.

---
 rtl/rs_pkg.sv | 33 +++
 rtl/fu_alu.sv | 47 ++++
 rtl/functional_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: opcode encodings, tag width, FU state.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Imported by decode, the reservation station, the functional units and the
// forwarding checker so every consumer agrees on the alu_type encoding.
package rs_pkg;

    // Physical register tag / ROB index width used across the issue path.
    localparam int TAG_W = 6;

    // alu_type encodings. Code 0 and 12..15 are unassigned and yield 0.
    localparam logic [3:0] ALU_NOP   = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    // Functional-unit slot state.
    typedef enum logic [1:0] {
        FU_IDLE = 2'd0,
        FU_EXEC = 2'd1,
        FU_WB   = 2'd2
    } fu_state_t;

endpackage

// File: rtl/fu_alu.sv
// Combinational 32-bit integer ALU / address generator for one FU slot.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller registers the result.
//
// Ports:
//   op     - alu_type opcode (rs_pkg encodings)
//   a, b   - operands; b is already muxed (rs2 or imm) by the caller
//   is_ls  - address generation: result is a + b regardless of op
//   result - 32-bit result, truncated, no overflow indication
module fu_alu
    import rs_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_ls,
    output logic [31:0] result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = 32'd0;
        if (is_ls) begin
            // Effective address; the caller guarantees b is the immediate.
            result = a + b;
        end else begin
            case (op)
                ALU_ADD:   result = a + b;
                ALU_SUB:   result = a - b;
                ALU_AND:   result = a & b;
                ALU_OR:    result = a | b;
                ALU_XOR:   result = a ^ b;
                ALU_SLL:   result = a << shamt;
                ALU_SRL:   result = a >> shamt;
                ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
                ALU_SLT:   result = {31'd0, ($signed(a) < $signed(b))};
                ALU_SLTU:  result = {31'd0, (a < b)};
                ALU_PASSB: result = b;
                default:   result = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/functional_unit.sv
// Single-issue execution slot: accepts one micro-op, runs it EXEC_LATENCY cycles, holds it for the CDB.
// Latency: issue accepted at edge E -> wb_valid from edge E+EXEC_LATENCY-1; one op per EXEC_LATENCY+1 cycles.
// Backpressure: fu_ready low while busy; result held until wb_grant; issue while busy is dropped and flagged.
//
// Ports:
//   clk, reset_n        - clock, synchronous active-low reset
//   flush               - squash any in-flight op (next edge -> idle)
//   issue_*             - micro-op fields from the reservation station
//   fu_ready            - slot empty, an issue this cycle will be accepted
//   wb_valid, wb_grant  - result request / acceptance with the CDB arbiter
//   wb_*                - captured result and tags, stable throughout writeback
//   issue_overrun       - sticky: an issue arrived while fu_ready was low
module functional_unit #(
    parameter int EXEC_LATENCY = 1,   // legal range 1..15
    parameter int TAG_W        = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic             issue_is_LS,
    input  logic             issue_alusrc,
    input  logic [3:0]       issue_alu_type,
    input  logic [TAG_W-1:0] issue_rd_tag,
    input  logic [TAG_W-1:0] issue_rob_num,
    input  logic [31:0]      issue_rs1_val,
    input  logic [31:0]      issue_rs2_val,
    input  logic [31:0]      issue_imm,
    output logic             fu_ready,
    output logic             wb_valid,
    input  logic             wb_grant,
    output logic [31:0]      wb_value,
    output logic [31:0]      wb_store_data,
    output logic [TAG_W-1:0] wb_rd_tag,
    output logic [TAG_W-1:0] wb_rob_num,
    output logic             wb_is_LS,
    output logic             issue_overrun
);

    import rs_pkg::*;

    // EXEC counts down from EXEC_LATENCY-2 to 0; with latency 1 the counter
    // is never loaded, so clamp the constant to stay non-negative.
    localparam int          CNT_INIT_I = (EXEC_LATENCY >= 2) ? (EXEC_LATENCY - 2) : 0;
    localparam logic [3:0]  CNT_INIT   = 4'(CNT_INIT_I);
    localparam logic        SKIP_EXEC  = (EXEC_LATENCY <= 1);

    fu_state_t   state;
    logic [3:0]  cnt;

    logic [31:0] alu_b;
    logic [31:0] alu_result;

    // Address generation always adds the immediate, whatever alusrc says.
    assign alu_b = (issue_alusrc || issue_is_LS) ? issue_imm : issue_rs2_val;

    fu_alu u_alu (
        .op     (issue_alu_type),
        .a      (issue_rs1_val),
        .b      (alu_b),
        .is_ls  (issue_is_LS),
        .result (alu_result)
    );

    // Handshake outputs are pure state decodes: no input-to-output path.
    assign fu_ready = (state == FU_IDLE);
    assign wb_valid = (state == FU_WB);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= FU_IDLE;
            cnt           <= 4'd0;
            wb_value      <= 32'd0;
            wb_store_data <= 32'd0;
            wb_rd_tag     <= '0;
            wb_rob_num    <= '0;
            wb_is_LS      <= 1'b0;
            issue_overrun <= 1'b0;
        end else if (flush) begin
            // Captured data is left in place; wb_valid low makes it dead.
            // A simultaneous issue or grant is deliberately ignored.
            state <= FU_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                FU_IDLE: begin
                    if (issue_valid) begin
                        wb_value      <= alu_result;
                        wb_store_data <= issue_rs2_val;
                        wb_rd_tag     <= issue_rd_tag;
                        wb_rob_num    <= issue_rob_num;
                        wb_is_LS      <= issue_is_LS;
                        cnt           <= CNT_INIT;
                        state         <= SKIP_EXEC ? FU_WB : FU_EXEC;
                    end
                end

                FU_EXEC: begin
                    if (issue_valid) begin
                        issue_overrun <= 1'b1;
                    end
                    if (cnt == 4'd0) begin
                        state <= FU_WB;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                FU_WB: begin
                    if (issue_valid) begin
                        issue_overrun <= 1'b1;
                    end
                    if (wb_grant) begin
                        state <= FU_IDLE;
                    end
                end

                default: begin
                    state <= FU_IDLE;
                end
            endcase
        end
    end

endmodule
